// File: rtl/cv32e40x_controller_scoreboard.sv
// Register-file hazard scoreboard: counts outstanding writes per GPR from ID
// issue to WB retire/cancel, flags RAW hazards per read port and throttles issue.
module cv32e40x_controller_scoreboard #(
    parameter int REGFILE_NUM_READ_PORTS = 2,
    parameter int ADDR_WIDTH             = 5,
    parameter int MAX_INFLIGHT           = 4,
    parameter int CNT_W                  = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         issue_valid_i,
    input  logic                                         issue_we_i,
    input  logic [ADDR_WIDTH-1:0]                        issue_waddr_i,
    input  logic                                         retire_valid_i,
    input  logic [ADDR_WIDTH-1:0]                        retire_waddr_i,
    input  logic                                         cancel_valid_i,
    input  logic [ADDR_WIDTH-1:0]                        cancel_waddr_i,
    input  logic                                         flush_i,
    input  logic [REGFILE_NUM_READ_PORTS-1:0]            rf_re_id_i,
    input  logic [REGFILE_NUM_READ_PORTS*ADDR_WIDTH-1:0] rf_raddr_id_i,
    output logic [REGFILE_NUM_READ_PORTS-1:0]            hazard_o,
    output logic                                         stall_issue_o,
    output logic                                         full_o,
    output logic                                         empty_o,
    output logic [CNT_W-1:0]                             inflight_cnt_o,
    output logic                                         err_o
);

    localparam int NREG = 2 ** ADDR_WIDTH;

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic [CNT_W-1:0] total_q, total_d;
    logic             err_q, err_d;

    logic inc, dec_r, dec_c, issue_rej, underflow;
    int   nxt, fix, tot;

    always_comb begin
        inc       = issue_valid_i && issue_we_i && (issue_waddr_i != '0) && !full_o;
        issue_rej = issue_valid_i && issue_we_i && (issue_waddr_i != '0) && full_o;
        dec_r     = retire_valid_i && (retire_waddr_i != '0);
        dec_c     = cancel_valid_i && (cancel_waddr_i != '0);
        underflow = 1'b0;
        fix       = 0;
        nxt       = 0;
        cnt_d[0]  = '0;
        // Net change per entry; a clamped entry hands its shortfall back to the total.
        for (int a = 1; a < NREG; a++) begin
            nxt = int'(cnt_q[a])
                + int'(inc   && (issue_waddr_i  == ADDR_WIDTH'(a)))
                - int'(dec_r && (retire_waddr_i == ADDR_WIDTH'(a)))
                - int'(dec_c && (cancel_waddr_i == ADDR_WIDTH'(a)));
            if (nxt < 0) begin
                cnt_d[a]  = '0;
                underflow = 1'b1;
                fix       = fix - nxt;
            end else begin
                cnt_d[a] = CNT_W'(nxt);
            end
        end
        tot = int'(total_q) + int'(inc) - int'(dec_r) - int'(dec_c) + fix;
        if (tot < 0) begin
            total_d = '0;
        end else begin
            total_d = CNT_W'(tot);
        end
        err_d = err_q | (!flush_i & (issue_rej | underflow));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < NREG; a++) cnt_q[a] <= '0;
            total_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (flush_i) begin
                for (int a = 0; a < NREG; a++) cnt_q[a] <= '0;
                total_q <= '0;
            end else begin
                for (int a = 0; a < NREG; a++) cnt_q[a] <= cnt_d[a];
                total_q <= total_d;
            end
            err_q <= err_d;
        end
    end

    always_comb begin
        hazard_o = '0;
        for (int p = 0; p < REGFILE_NUM_READ_PORTS; p++) begin
            hazard_o[p] = rf_re_id_i[p]
                       && (rf_raddr_id_i[p*ADDR_WIDTH +: ADDR_WIDTH] != '0)
                       && (cnt_q[rf_raddr_id_i[p*ADDR_WIDTH +: ADDR_WIDTH]] != '0);
        end
    end

    assign full_o         = (total_q == CNT_W'(MAX_INFLIGHT));
    assign empty_o        = (total_q == '0);
    assign stall_issue_o  = (|hazard_o) || full_o;
    assign inflight_cnt_o = total_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_cv32e40x_controller_scoreboard.sv
// Directed bench for the hazard scoreboard: each stimulus row queues the outputs
// it must see that cycle; a negedge monitor pops and compares them.
module tb_cv32e40x_controller_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       issue_valid, issue_we, retire_valid, cancel_valid, flush;
    logic [4:0] issue_waddr, retire_waddr, cancel_waddr;
    logic [1:0] rf_re;
    logic [9:0] rf_raddr;
    logic [1:0] hazard;
    logic       stall_issue, full, empty, err;
    logic [2:0] inflight_cnt;

    typedef struct {
        string      name;
        logic [1:0] hz;
        logic       stall;
        logic       full;
        logic       empty;
        logic [2:0] cnt;
        logic       err;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   passed = 0;

    cv32e40x_controller_scoreboard #(
        .REGFILE_NUM_READ_PORTS(2),
        .ADDR_WIDTH(5),
        .MAX_INFLIGHT(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .issue_valid_i(issue_valid),
        .issue_we_i(issue_we),
        .issue_waddr_i(issue_waddr),
        .retire_valid_i(retire_valid),
        .retire_waddr_i(retire_waddr),
        .cancel_valid_i(cancel_valid),
        .cancel_waddr_i(cancel_waddr),
        .flush_i(flush),
        .rf_re_id_i(rf_re),
        .rf_raddr_id_i(rf_raddr),
        .hazard_o(hazard),
        .stall_issue_o(stall_issue),
        .full_o(full),
        .empty_o(empty),
        .inflight_cnt_o(inflight_cnt),
        .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic cmpField(input string name, input string field, input logic [2:0] got, input logic [2:0] want);
        checks++;
        if (got === want) passed++;
        else $display("[TB] FAIL %s.%s got %0b want %0b", name, field, got, want);
    endtask

    task automatic checkOutput(input exp_t e);
        cmpField(e.name, "hazard", {1'b0, hazard}, {1'b0, e.hz});
        cmpField(e.name, "stall", {2'b0, stall_issue}, {2'b0, e.stall});
        cmpField(e.name, "full", {2'b0, full}, {2'b0, e.full});
        cmpField(e.name, "empty", {2'b0, empty}, {2'b0, e.empty});
        cmpField(e.name, "cnt", inflight_cnt, e.cnt);
        cmpField(e.name, "err", {2'b0, err}, {2'b0, e.err});
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end

    // One cycle of stimulus plus the outputs expected in that same cycle.
    task automatic applyStimulus(
        input string name, input logic rstn,
        input logic iv, input logic iwe, input logic [4:0] ia,
        input logic rv, input logic [4:0] ra,
        input logic cv, input logic [4:0] ca,
        input logic fl, input logic [1:0] re, input logic [4:0] r0, input logic [4:0] r1,
        input logic [1:0] ehz, input logic est, input logic efu, input logic eem,
        input logic [2:0] ecnt, input logic eerr);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n        = rstn;
        issue_valid  = iv;
        issue_we     = iwe;
        issue_waddr  = ia;
        retire_valid = rv;
        retire_waddr = ra;
        cancel_valid = cv;
        cancel_waddr = ca;
        flush        = fl;
        rf_re        = re;
        rf_raddr     = {r1, r0};
        e.name = name; e.hz = ehz; e.stall = est; e.full = efu;
        e.empty = eem; e.cnt = ecnt; e.err = eerr;
        expQ.push_back(e);
    endtask

    initial begin
        issue_valid = 0; issue_we = 0; issue_waddr = 0;
        retire_valid = 0; retire_waddr = 0;
        cancel_valid = 0; cancel_waddr = 0;
        flush = 0; rf_re = 0; rf_raddr = 0;
        #1 rst_n = 1'b0;
        //            name       rst iv we ia  rv ra  cv ca  fl re     r0 r1   hz     st fu em cnt err
        applyStimulus("rst0",    0, 0, 0, 0,  0, 0,  0, 0,  0, 2'b00, 0, 0,  2'b00, 0, 0, 1, 0, 0);
        applyStimulus("reset",   1, 0, 0, 0,  0, 0,  0, 0,  0, 2'b00, 0, 0,  2'b00, 0, 0, 1, 0, 0);
        applyStimulus("iss5",    1, 1, 1, 5,  0, 0,  0, 0,  0, 2'b10, 0, 5,  2'b00, 0, 0, 1, 0, 0);
        applyStimulus("haz5",    1, 0, 0, 0,  0, 0,  0, 0,  0, 2'b10, 0, 5,  2'b10, 1, 0, 0, 1, 0);
        applyStimulus("ret5",    1, 0, 0, 0,  1, 5,  0, 0,  0, 2'b10, 0, 5,  2'b10, 1, 0, 0, 1, 0);
        applyStimulus("clr5",    1, 0, 0, 0,  0, 0,  0, 0,  0, 2'b10, 0, 5,  2'b00, 0, 0, 1, 0, 0);
        applyStimulus("iss7a",   1, 1, 1, 7,  0, 0,  0, 0,  0, 2'b01, 7, 0,  2'b00, 0, 0, 1, 0, 0);
        applyStimulus("iss7b",   1, 1, 1, 7,  0, 0,  0, 0,  0, 2'b01, 7, 0,  2'b01, 1, 0, 0, 1, 0);
        applyStimulus("ret7a",   1, 0, 0, 0,  1, 7,  0, 0,  0, 2'b01, 7, 0,  2'b01, 1, 0, 0, 2, 0);
        applyStimulus("issret7", 1, 1, 1, 7,  1, 7,  0, 0,  0, 2'b01, 7, 0,  2'b01, 1, 0, 0, 1, 0);
        applyStimulus("ret7b",   1, 0, 0, 0,  1, 7,  0, 0,  0, 2'b01, 7, 0,  2'b01, 1, 0, 0, 1, 0);
        applyStimulus("clr7",    1, 0, 0, 0,  0, 0,  0, 0,  0, 2'b01, 7, 0,  2'b00, 0, 0, 1, 0, 0);
        applyStimulus("iss3",    1, 1, 1, 3,  0, 0,  0, 0,  0, 2'b01, 3, 0,  2'b00, 0, 0, 1, 0, 0);
        applyStimulus("can3",    1, 0, 0, 0,  0, 0,  1, 3,  0, 2'b01, 3, 0,  2'b01, 1, 0, 0, 1, 0);
        applyStimulus("under3",  1, 0, 0, 0,  1, 3,  0, 0,  0, 2'b01, 3, 0,  2'b00, 0, 0, 1, 0, 0);
        applyStimulus("errset",  1, 0, 0, 0,  0, 0,  0, 0,  0, 2'b01, 3, 0,  2'b00, 0, 0, 1, 0, 1);
        applyStimulus("rst1",    0, 0, 0, 0,  0, 0,  0, 0,  0, 2'b00, 0, 0,  2'b00, 0, 0, 1, 0, 0);
        applyStimulus("rst2",    1, 0, 0, 0,  0, 0,  0, 0,  0, 2'b00, 0, 0,  2'b00, 0, 0, 1, 0, 0);
        applyStimulus("fill1",   1, 1, 1, 1,  0, 0,  0, 0,  0, 2'b00, 0, 0,  2'b00, 0, 0, 1, 0, 0);
        applyStimulus("fill2",   1, 1, 1, 2,  0, 0,  0, 0,  0, 2'b00, 0, 0,  2'b00, 0, 0, 0, 1, 0);
        applyStimulus("fill3",   1, 1, 1, 3,  0, 0,  0, 0,  0, 2'b00, 0, 0,  2'b00, 0, 0, 0, 2, 0);
        applyStimulus("fill4",   1, 1, 1, 4,  0, 0,  0, 0,  0, 2'b00, 0, 0,  2'b00, 0, 0, 0, 3, 0);
        applyStimulus("iss9",    1, 1, 1, 9,  0, 0,  0, 0,  0, 2'b11, 9, 1,  2'b10, 1, 1, 0, 4, 0);
        applyStimulus("fullerr", 1, 0, 0, 0,  0, 0,  0, 0,  0, 2'b11, 9, 1,  2'b10, 1, 1, 0, 4, 1);
        applyStimulus("drain1",  1, 0, 0, 0,  1, 1,  0, 0,  0, 2'b00, 0, 0,  2'b00, 1, 1, 0, 4, 1);
        applyStimulus("drain2",  1, 0, 0, 0,  1, 2,  0, 0,  0, 2'b00, 0, 0,  2'b00, 0, 0, 0, 3, 1);
        applyStimulus("drain3",  1, 0, 0, 0,  1, 3,  0, 0,  0, 2'b00, 0, 0,  2'b00, 0, 0, 0, 2, 1);
        applyStimulus("iss5b",   1, 1, 1, 5,  0, 0,  0, 0,  0, 2'b00, 0, 0,  2'b00, 0, 0, 0, 1, 1);
        applyStimulus("iss6",    1, 1, 1, 6,  0, 0,  0, 0,  0, 2'b00, 0, 0,  2'b00, 0, 0, 0, 2, 1);
        applyStimulus("flush",   1, 1, 1, 8,  0, 0,  0, 0,  1, 2'b11, 4, 8,  2'b01, 1, 0, 0, 3, 1);
        applyStimulus("postfl",  1, 0, 0, 0,  0, 0,  0, 0,  0, 2'b11, 4, 8,  2'b00, 0, 0, 1, 0, 1);
        applyStimulus("issx0",   1, 1, 1, 0,  0, 0,  0, 0,  0, 2'b11, 0, 0,  2'b00, 0, 0, 1, 0, 1);
        applyStimulus("readx0",  1, 0, 0, 0,  0, 0,  0, 0,  0, 2'b11, 0, 0,  2'b00, 0, 0, 1, 0, 1);
        applyStimulus("iss10",   1, 1, 1, 10, 0, 0,  0, 0,  0, 2'b00, 0, 0,  2'b00, 0, 0, 1, 0, 1);
        applyStimulus("iss11",   1, 1, 1, 11, 0, 0,  0, 0,  0, 2'b00, 0, 0,  2'b00, 0, 0, 0, 1, 1);
        applyStimulus("prerst",  1, 0, 0, 0,  0, 0,  0, 0,  0, 2'b11, 10, 11, 2'b11, 1, 0, 0, 2, 1);
        // rst_n drops #1 after the edge; the negedge check precedes any further posedge.
        applyStimulus("asyncrst",0, 0, 0, 0,  0, 0,  0, 0,  0, 2'b11, 10, 11, 2'b00, 0, 0, 1, 0, 0);
        applyStimulus("rstheld", 0, 1, 1, 12, 0, 0,  0, 0,  0, 2'b11, 10, 12, 2'b00, 0, 0, 1, 0, 0);
        applyStimulus("rstdone", 1, 0, 0, 0,  0, 0,  0, 0,  0, 2'b11, 10, 12, 2'b00, 0, 0, 1, 0, 0);

        for (int i = 0; i < 5 && expQ.size() > 0; i++) @(posedge clk);
        checks++;
        if (expQ.size() == 0) passed++;
        else $display("[TB] FAIL drain: %0d expectations left, want 0", expQ.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
